// File: rtl/i3c_bus_filter.sv
// I3C pad input conditioning: synchronizers, spike filter, bus event pulses and busy/idle tracking.
// Optional SCL stall detector is compiled in with `define I3C_SCL_STALL_DET_EN.
module i3c_bus_filter #(
    parameter int unsigned SyncStages   = 2,
    parameter int unsigned FiltCntWidth = 4,
    parameter int unsigned IdleCntWidth = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    scl_i,
    input  logic                    sda_i,
    input  logic [FiltCntWidth-1:0] filt_cycles_i,
    input  logic [IdleCntWidth-1:0] idle_cycles_i,
`ifdef I3C_SCL_STALL_DET_EN
    input  logic [19:0]             stall_cycles_i,
    output logic                    scl_stall_o,
`endif
    output logic                    scl_o,
    output logic                    sda_o,
    output logic                    scl_rise_o,
    output logic                    scl_fall_o,
    output logic                    start_o,
    output logic                    rstart_o,
    output logic                    stop_o,
    output logic                    bus_busy_o,
    output logic                    bus_idle_o
);

    // Line index 0 = SCL, 1 = SDA throughout.
    logic [1:0]              pad;
    logic [SyncStages-1:0]   sync_q   [2];
    logic [FiltCntWidth-1:0] filt_cnt [2];
    logic [1:0]              filt_q;
    logic [1:0]              prev_q;

    logic                    scl_high_both;
    logic                    sda_fall;
    logic                    sda_rise;
    logic                    start_det;
    logic                    stop_det;
    logic                    both_high;
    logic [IdleCntWidth-1:0] idle_cnt;
    logic [IdleCntWidth-1:0] idle_cnt_next;
    logic                    idle_next;
    logic                    busy_next;

    assign pad   = {sda_i, scl_i};
    assign scl_o = filt_q[0];
    assign sda_o = filt_q[1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < 2; i++) begin
                sync_q[i]   <= '1;
                filt_cnt[i] <= '0;
            end
            filt_q <= '1;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                sync_q[i] <= {sync_q[i][SyncStages-2:0], pad[i]};
                if (sync_q[i][SyncStages-1] == filt_q[i]) begin
                    filt_cnt[i] <= '0;
                end else if (filt_cnt[i] >= filt_cycles_i) begin
                    filt_q[i]   <= sync_q[i][SyncStages-1];
                    filt_cnt[i] <= '0;
                end else if (filt_cnt[i] != '1) begin
                    filt_cnt[i] <= filt_cnt[i] + 1'b1;
                end
            end
        end
    end

    // START/STOP need SCL stably high across both samples so a simultaneous SCL edge masks them.
    always_comb begin
        scl_high_both = filt_q[0] & prev_q[0];
        sda_fall      = prev_q[1] & ~filt_q[1];
        sda_rise      = ~prev_q[1] & filt_q[1];
        start_det     = scl_high_both & sda_fall;
        stop_det      = scl_high_both & sda_rise;
        both_high     = filt_q[0] & filt_q[1];

        idle_cnt_next = '0;
        if (both_high) begin
            idle_cnt_next = (idle_cnt == '1) ? idle_cnt : idle_cnt + 1'b1;
        end
        // Qualified by both_high so idle_cycles_i=0 still requires the lines to be high.
        idle_next = both_high & (idle_cnt_next >= idle_cycles_i);

        busy_next = bus_busy_o;
        if (!enable_i) begin
            busy_next = 1'b0;
        end else if (start_det) begin
            busy_next = 1'b1;
        end else if (stop_det || (idle_next && !bus_idle_o)) begin
            busy_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q     <= '1;
            scl_rise_o <= 1'b0;
            scl_fall_o <= 1'b0;
            start_o    <= 1'b0;
            rstart_o   <= 1'b0;
            stop_o     <= 1'b0;
            bus_busy_o <= 1'b0;
            bus_idle_o <= 1'b0;
            idle_cnt   <= '0;
        end else begin
            prev_q     <= filt_q;
            scl_rise_o <= enable_i & filt_q[0] & ~prev_q[0];
            scl_fall_o <= enable_i & ~filt_q[0] & prev_q[0];
            start_o    <= enable_i & start_det & ~bus_busy_o;
            rstart_o   <= enable_i & start_det & bus_busy_o;
            stop_o     <= enable_i & stop_det;
            bus_busy_o <= busy_next;
            bus_idle_o <= idle_next;
            idle_cnt   <= idle_cnt_next;
        end
    end

`ifdef I3C_SCL_STALL_DET_EN
    logic [19:0] stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt   <= '0;
            scl_stall_o <= 1'b0;
        end else begin
            if (!filt_q[0] && bus_busy_o) begin
                stall_cnt <= (stall_cnt == '1) ? stall_cnt : stall_cnt + 1'b1;
            end else begin
                stall_cnt <= '0;
            end
            if (scl_rise_o || stop_o) begin
                scl_stall_o <= 1'b0;
            end else if ((stall_cycles_i != '0) && (stall_cnt >= stall_cycles_i)) begin
                scl_stall_o <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_i3c_bus_filter.sv
// Self-checking bench for i3c_bus_filter: directed bus scenarios plus randomized pad activity
// compared every cycle against a cycle-level behavioural model of the filter and event rules.
module tb_i3c_bus_filter;

    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b1;
    logic        scl_i = 1'b1;
    logic        sda_i = 1'b1;
    logic [3:0]  filt = '0;
    logic [15:0] idle_cycles = 16'd8;
    logic        scl_o, sda_o, scl_rise, scl_fall, start, rstart, stop, busy, idle;
`ifdef I3C_SCL_STALL_DET_EN
    logic [19:0] stall_cycles = '0;
    logic        scl_stall;
`endif

    int checks = 0;
    int failures = 0;

    i3c_bus_filter #(
        .SyncStages  (SS),
        .FiltCntWidth(4),
        .IdleCntWidth(16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .scl_i        (scl_i),
        .sda_i        (sda_i),
        .filt_cycles_i(filt),
        .idle_cycles_i(idle_cycles),
`ifdef I3C_SCL_STALL_DET_EN
        .stall_cycles_i(stall_cycles),
        .scl_stall_o  (scl_stall),
`endif
        .scl_o        (scl_o),
        .sda_o        (sda_o),
        .scl_rise_o   (scl_rise),
        .scl_fall_o   (scl_fall),
        .start_o      (start),
        .rstart_o     (rstart),
        .stop_o       (stop),
        .bus_busy_o   (busy),
        .bus_idle_o   (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: line 0 = SCL, 1 = SDA. hist holds raw pad samples (newest at [0]);
    // a line's filtered level follows the synchronized level once it has disagreed for
    // more than filt consecutive cycles.
    bit hist [2][SS];
    bit mx [2];
    int disagree [2];
    bit mprev [2];
    bit m_rise, m_fall, m_start, m_rstart, m_stop, m_busy, m_idle;
    int m_run;
    bit steady, sfall, srise, nidle, nbusy, smp;
    int nrun;

    task automatic model_reset();
        for (int l = 0; l < 2; l++) begin
            for (int a = 0; a < SS; a++) hist[l][a] = 1'b1;
            mx[l] = 1'b1;
            disagree[l] = 0;
            mprev[l] = 1'b1;
        end
        m_rise = 0; m_fall = 0; m_start = 0; m_rstart = 0; m_stop = 0;
        m_busy = 0; m_idle = 0; m_run = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
            end else begin
                steady = mx[0] && mprev[0];
                sfall  = mprev[1] && !mx[1];
                srise  = !mprev[1] && mx[1];
                nrun   = (mx[0] && mx[1]) ? ((m_run < 65535) ? m_run + 1 : m_run) : 0;
                nidle  = mx[0] && mx[1] && (nrun >= int'(idle_cycles));
                if (!enable) nbusy = 0;
                else if (steady && sfall) nbusy = 1;
                else if ((steady && srise) || (nidle && !m_idle)) nbusy = 0;
                else nbusy = m_busy;
                m_rise   = enable && mx[0] && !mprev[0];
                m_fall   = enable && !mx[0] && mprev[0];
                m_start  = enable && steady && sfall && !m_busy;
                m_rstart = enable && steady && sfall && m_busy;
                m_stop   = enable && steady && srise;
                m_busy   = nbusy;
                m_idle   = nidle;
                m_run    = nrun;
                for (int l = 0; l < 2; l++) begin
                    mprev[l] = mx[l];
                    smp = hist[l][SS-1];
                    if (smp != mx[l]) begin
                        if (disagree[l] >= int'(filt)) begin
                            mx[l] = smp;
                            disagree[l] = 0;
                        end else if (disagree[l] < 15) begin
                            disagree[l]++;
                        end
                    end else begin
                        disagree[l] = 0;
                    end
                    for (int a = SS - 1; a > 0; a--) hist[l][a] = hist[l][a-1];
                    hist[l][0] = (l == 0) ? scl_i : sda_i;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("scl_o", int'(scl_o), int'(mx[0]));
            check("sda_o", int'(sda_o), int'(mx[1]));
            check("scl_rise", int'(scl_rise), int'(m_rise));
            check("scl_fall", int'(scl_fall), int'(m_fall));
            check("start", int'(start), int'(m_start));
            check("rstart", int'(rstart), int'(m_rstart));
            check("stop", int'(stop), int'(m_stop));
            check("busy", int'(busy), int'(m_busy));
            check("idle", int'(idle), int'(m_idle));
        end
    end

    int n_start, n_rstart, n_stop, n_rise, n_fall, n_sda_low;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic watch(input int n);
        n_start = 0; n_rstart = 0; n_stop = 0; n_rise = 0; n_fall = 0; n_sda_low = 0;
        repeat (n) begin
            @(negedge clk);
            n_start   += int'(start);
            n_rstart  += int'(rstart);
            n_stop    += int'(stop);
            n_rise    += int'(scl_rise);
            n_fall    += int'(scl_fall);
            n_sda_low += int'(!sda_o);
        end
        #1;
    endtask

    int k;
    int first_stop, first_idle;
    bit got;

    initial begin
        #1 rst = 1'b1;
        #2;
        check("rst_scl_o", int'(scl_o), 1);
        check("rst_sda_o", int'(sda_o), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_idle", int'(idle), 0);
        check("rst_start", int'(start), 0);
        tick(2);
        rst = 1'b0;
        tick(12);

        // Filter latency and glitch rejection with filt=3.
        filt = 4'd3;
        tick(2);
        sda_i = 1'b0;
        k = 0; got = 0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            if (sda_o == 1'b0) got = 1;
            else if (k == 4) #1 sda_i = 1'b1;
        end
        #1;
        sda_i = 1'b1;
        check("t1_fall_edges", k, 6);
        tick(25);
        sda_i = 1'b0;
        tick(3);
        sda_i = 1'b1;
        watch(15);
        check("t1_glitch_sda_low", n_sda_low, 0);
        check("t1_glitch_start", n_start, 0);
        check("t1_glitch_stop", n_stop, 0);

        // START then repeated START.
        filt = 4'd0;
        tick(15);
        sda_i = 1'b0;
        watch(8);
        check("t2_start", n_start, 1);
        check("t2_busy", int'(busy), 1);
        scl_i = 1'b0; tick(4);
        sda_i = 1'b1; tick(4);
        scl_i = 1'b1; tick(4);
        sda_i = 1'b0;
        watch(8);
        check("t2_rstart", n_rstart, 1);
        check("t2_no_start", n_start, 0);
        check("t2_busy_kept", int'(busy), 1);

        // STOP and idle timing with idle_cycles=8.
        sda_i = 1'b1;
        first_stop = 0; first_idle = 0;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            if (stop && first_stop == 0) first_stop = j;
            if (idle && first_idle == 0) first_idle = j;
        end
        #1;
        check("t3_stop_at", first_stop, 4);
        check("t3_idle_at", first_idle, 11);
        check("t3_busy_clr", int'(busy), 0);

        // Simultaneous SCL/SDA fall gives only the SCL edge.
        scl_i = 1'b0; sda_i = 1'b0;
        watch(8);
        check("t4_fall", n_fall, 1);
        check("t4_no_start", n_start, 0);
        scl_i = 1'b1; sda_i = 1'b1;
        watch(8);
        check("t4_rise", n_rise, 1);
        check("t4_no_stop", n_stop, 0);

        // Asynchronous reset in the middle of a transfer.
        tick(12);
        sda_i = 1'b0; tick(5);
        scl_i = 1'b0; tick(5);
        check("t5_busy_pre", int'(busy), 1);
        check("t5_scl_pre", int'(scl_o), 0);
        #2 rst = 1'b1;
        #1;
        check("t5_scl_rst", int'(scl_o), 1);
        check("t5_sda_rst", int'(sda_o), 1);
        check("t5_busy_rst", int'(busy), 0);
        scl_i = 1'b1; sda_i = 1'b1;
        tick(1);
        rst = 1'b0;
        watch(10);
        check("t5_no_stop", n_stop, 0);
        check("t5_no_start", n_start, 0);

`ifdef I3C_SCL_STALL_DET_EN
        stall_cycles = 20'd100;
        tick(12);
        sda_i = 1'b0; tick(5);
        scl_i = 1'b0; tick(110);
        check("t6_stall_set", int'(scl_stall), 1);
        scl_i = 1'b1; tick(8);
        check("t6_stall_clr", int'(scl_stall), 0);
        sda_i = 1'b1; tick(10);
        stall_cycles = '0;
`endif

        // Randomized pad activity, filter/idle settings, enable and one async reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) scl_i = ~scl_i;
            if ($urandom_range(4) == 0) sda_i = ~sda_i;
            if ($urandom_range(150) == 0) filt = 4'($urandom_range(4));
            if ($urandom_range(200) == 0) idle_cycles = 16'($urandom_range(12));
            if (enable && $urandom_range(250) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(9) == 0) enable = 1'b1;
            if (i == 1500) begin
                #2 rst = 1'b1;
                tick(2);
                rst = 1'b0;
            end else begin
                tick(1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
